// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_boot_loader
//  Purpose  : Boot-time program loader for the single-cycle CPU. Accepts a
//             byte stream (valid/ready), packs bytes big-endian into 32-bit
//             words, writes them to the instruction memory, zero-fills the
//             rest of the memory, then releases the CPU from reset.
//  Ports    : clk_i, rst_i          - clock, synchronous active-high reset
//             byte_i/_valid_i/_last_i, byte_ready_o - byte stream handshake
//             imem_we_o/_addr_o/_data_o             - imem write port
//             cpu_rst_o, start_o    - CPU reset release / start (1 = run)
//             loaded_words_o        - program words written (no zero-fill)
//             error_o               - sticky: byte offered after loading
//  Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    input  logic              byte_last_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              cpu_rst_o,
    output logic              start_o,
    output logic [ADDR_W:0]   loaded_words_o,
    output logic              error_o
);

    localparam logic [ADDR_W:0] c_DEPTH     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] c_ONE       = (ADDR_W+1)'(1);

    if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
        $error("imem_boot_loader: DEPTH must equal 2**ADDR_W");
    end

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [1:0]        r_lane;      // next byte lane to fill (0 = MSB)
    logic [31:0]       r_asm;       // partially assembled word
    logic [ADDR_W:0]   r_count;     // next imem address (program + fill)
    logic [ADDR_W:0]   r_loaded;    // program words only
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              r_error;

    logic              w_accept;
    logic              w_close;
    logic              w_fill_wr;
    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_count_inc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        byte_ready_o = 1'b0;
        w_accept     = 1'b0;
        w_close      = 1'b0;
        w_fill_wr    = 1'b0;
        w_count_inc  = r_count + c_ONE;

        // Current byte merged into its lane. Lanes above it are still zero
        // because the assembly register is cleared whenever a word closes.
        w_word = r_asm;
        case (r_lane)
            2'd0:    w_word[31:24] = byte_i;
            2'd1:    w_word[23:16] = byte_i;
            2'd2:    w_word[15:8]  = byte_i;
            default: w_word[7:0]   = byte_i;
        endcase

        case (r_state)
            S_LOAD: begin
                byte_ready_o = 1'b1;
                w_accept     = byte_valid_i;
                w_close      = byte_valid_i && ((r_lane == 2'd3) || byte_last_i);
                if (w_close) begin
                    // A full memory wins over byte_last_i: nothing left to fill.
                    if (w_count_inc == c_DEPTH) begin
                        w_state_nxt = S_RUN;
                    end else if (byte_last_i) begin
                        w_state_nxt = S_FILL;
                    end
                end
            end
            S_FILL: begin
                w_fill_wr = 1'b1;
                if (r_count == c_LAST_ADDR) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: word assembly, write port, counters, sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lane   <= 2'd0;
            r_asm    <= 32'd0;
            r_count  <= '0;
            r_loaded <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= 32'd0;
            r_error  <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                if (w_close) begin
                    r_asm    <= 32'd0;
                    r_lane   <= 2'd0;
                    r_we     <= 1'b1;
                    r_addr   <= r_count[ADDR_W-1:0];
                    r_data   <= w_word;
                    r_count  <= w_count_inc;
                    r_loaded <= r_loaded + c_ONE;
                end else begin
                    r_asm  <= w_word;
                    r_lane <= r_lane + 2'd1;
                end
            end else if (w_fill_wr) begin
                r_we    <= 1'b1;
                r_addr  <= r_count[ADDR_W-1:0];
                r_data  <= 32'd0;
                r_count <= w_count_inc;
            end

            if ((r_state != S_LOAD) && byte_valid_i) begin
                r_error <= 1'b1;
            end
        end
    end

    assign imem_we_o      = r_we;
    assign imem_addr_o    = r_addr;
    assign imem_data_o    = r_data;
    assign loaded_words_o = r_loaded;
    assign error_o        = r_error;

    // RUN is entered on the same edge that registers the final write; the
    // release is held back while that write pulse is still on the port.
    assign cpu_rst_o = (r_state == S_RUN) && !r_we;
    assign start_o   = (r_state == S_RUN) && !r_we;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_boot_loader
//  Purpose  : Self-checking bench for imem_boot_loader. Expected memory image,
//             write timing and release timing are computed from the byte list
//             and the cycles at which each byte was offered.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [7:0]        byte_i = 8'd0;
    logic              byte_valid_i = 1'b0;
    logic              byte_last_i = 1'b0;
    logic              byte_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_data_o;
    logic              cpu_rst_o;
    logic              start_o;
    logic [ADDR_W:0]   loaded_words_o;
    logic              error_o;

    imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .byte_i         (byte_i),
        .byte_valid_i   (byte_valid_i),
        .byte_last_i    (byte_last_i),
        .byte_ready_o   (byte_ready_o),
        .imem_we_o      (imem_we_o),
        .imem_addr_o    (imem_addr_o),
        .imem_data_o    (imem_data_o),
        .cpu_rst_o      (cpu_rst_o),
        .start_o        (start_o),
        .loaded_words_o (loaded_words_o),
        .error_o        (error_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Observed write log and release cycle
    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          run_cyc = -1;
    int          viol = 0;
    logic        prev_we = 1'b0;
    int          prev_addr = 0;

    always @(negedge clk_i) begin
        if (imem_we_o) begin
            wr_addr.push_back(int'(imem_addr_o));
            wr_data.push_back(imem_data_o);
            wr_cyc.push_back(cyc);
            if (cpu_rst_o || start_o) viol++;
            if (prev_we && (prev_addr == int'(imem_addr_o))) viol++;
        end
        if (cpu_rst_o && (run_cyc < 0)) run_cyc = cyc;
        prev_we   = imem_we_o;
        prev_addr = int'(imem_addr_o);
    end

    // Stimulus description
    logic [7:0] prog[$];
    int         gaps[$];
    int         drv_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: word w of the program, big-endian, missing bytes zero
    function automatic logic [31:0] exp_word(input int w);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if ((4*w + k) < prog.size()) v[31-8*k -: 8] = prog[4*w + k];
        end
        return v;
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk_i);
        rst_i        = 1'b1;
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        @(negedge clk_i);
        chk({tag, ".rst_ready"}, byte_ready_o, 1);
        chk({tag, ".rst_we"}, imem_we_o, 0);
        chk({tag, ".rst_addr"}, imem_addr_o, 0);
        chk({tag, ".rst_data"}, imem_data_o, 0);
        chk({tag, ".rst_cpu"}, cpu_rst_o, 0);
        chk({tag, ".rst_start"}, start_o, 0);
        chk({tag, ".rst_loaded"}, loaded_words_o, 0);
        chk({tag, ".rst_err"}, error_o, 0);
        rst_i = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        run_cyc = -1;
    endtask

    task automatic send_prog(input string tag, input bit with_last, input int maxgap);
        int misses;
        int g;
        misses = 0;
        drv_cyc.delete();
        for (int i = 0; i < prog.size(); i++) begin
            if (i < gaps.size()) g = gaps[i];
            else g = int'($urandom_range(maxgap, 0));
            repeat (g) @(negedge clk_i);
            byte_i       = prog[i];
            byte_valid_i = 1'b1;
            byte_last_i  = with_last && (i == prog.size() - 1);
            if (!byte_ready_o) misses++;
            drv_cyc.push_back(cyc);
            @(negedge clk_i);
            byte_valid_i = 1'b0;
            byte_last_i  = 1'b0;
        end
        chk({tag, ".ready_in_load"}, misses, 0);
    endtask

    task automatic wait_run(input string tag);
        int t;
        t = 0;
        while ((run_cyc < 0) && (t < 600)) begin
            @(negedge clk_i);
            t++;
        end
        chk({tag, ".run_reached"}, (run_cyc >= 0), 1);
        repeat (2) @(negedge clk_i);
    endtask

    // Compare the whole write log and final status against the model
    task automatic verify(input string tag, input bit exp_err);
        int n, words, last_prog, ec, c127;
        n         = prog.size();
        words     = (n + 3) / 4;
        last_prog = drv_cyc[n-1] + 1;
        c127      = (words == DEPTH) ? last_prog : last_prog + (DEPTH - words);
        chk({tag, ".nwrites"}, wr_addr.size(), DEPTH);
        for (int a = 0; (a < DEPTH) && (a < wr_addr.size()); a++) begin
            if (a < words) ec = drv_cyc[((4*a + 3) < n) ? (4*a + 3) : (n - 1)] + 1;
            else ec = last_prog + (a - words + 1);
            chk($sformatf("%s.addr%0d", tag, a), wr_addr[a], a);
            chk($sformatf("%s.data%0d", tag, a), wr_data[a], (a < words) ? exp_word(a) : 32'd0);
            chk($sformatf("%s.cyc%0d", tag, a), wr_cyc[a], ec);
        end
        chk({tag, ".run_cyc"}, run_cyc, c127 + 1);
        chk({tag, ".loaded"}, loaded_words_o, words);
        chk({tag, ".cpu_rst"}, cpu_rst_o, 1);
        chk({tag, ".start"}, start_o, 1);
        chk({tag, ".ready_run"}, byte_ready_o, 0);
        chk({tag, ".err"}, error_o, exp_err);
        chk({tag, ".we_overlap"}, viol, 0);
    endtask

    task automatic offer_late_byte(input string tag);
        byte_i       = 8'h5A;
        byte_valid_i = 1'b1;
        chk({tag, ".late_ready"}, byte_ready_o, 0);
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        chk({tag, ".late_err"}, error_o, 1);
    endtask

    initial begin
        int nwr;
        // Test 1: 8 bytes, last on byte 8
        do_reset("t1");
        prog = {8'h8C, 8'h08, 8'h00, 8'h00, 8'h01, 8'h09, 8'h50, 8'h20};
        gaps.delete();
        send_prog("t1", 1'b1, 0);
        wait_run("t1");
        verify("t1", 1'b0);

        // Test 2: 6 bytes, partial final word
        do_reset("t2");
        prog = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        send_prog("t2", 1'b1, 0);
        wait_run("t2");
        verify("t2", 1'b0);

        // Test 3: 512 bytes without last fill the memory, then a late byte
        do_reset("t3");
        prog.delete();
        for (int i = 0; i < 4*DEPTH; i++) prog.push_back(8'($urandom));
        send_prog("t3", 1'b0, 0);
        wait_run("t3");
        verify("t3", 1'b0);
        offer_late_byte("t3");
        repeat (2) @(negedge clk_i);
        nwr = wr_addr.size();
        chk("t3.no_extra_write", nwr, DEPTH);
        chk("t3.err_sticky", error_o, 1);

        // Test 4: partial word discarded by reset
        do_reset("t4a");
        prog = {8'h01, 8'h02, 8'h03};
        send_prog("t4a", 1'b0, 0);
        do_reset("t4");
        prog = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_prog("t4", 1'b1, 0);
        wait_run("t4");
        verify("t4", 1'b0);

        // Test 5: byte offered during FILL
        do_reset("t5");
        prog = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h42};
        send_prog("t5", 1'b1, 0);
        repeat (4) @(negedge clk_i);
        offer_late_byte("t5");
        repeat (5) @(negedge clk_i);
        chk("t5.err_held", error_o, 1);
        wait_run("t5");
        verify("t5", 1'b1);

        // Test 6: gapped valid (bytes at relative cycles 0,3,4,9)
        do_reset("t6");
        prog = {8'hC0, 8'hFF, 8'hEE, 8'h01};
        gaps = {0, 2, 0, 4};
        send_prog("t6", 1'b1, 0);
        gaps.delete();
        wait_run("t6");
        verify("t6", 1'b0);

        // Randomized loads: random length, content and gaps
        for (int r = 0; r < 4; r++) begin
            do_reset($sformatf("rnd%0d", r));
            prog.delete();
            for (int i = 0; i < int'($urandom_range(90, 1)); i++) prog.push_back(8'($urandom));
            send_prog($sformatf("rnd%0d", r), 1'b1, 2);
            wait_run($sformatf("rnd%0d", r));
            verify($sformatf("rnd%0d", r), 1'b0);
        end

        // Boundary: full memory with last on the final byte
        do_reset("full_last");
        prog.delete();
        for (int i = 0; i < 4*DEPTH; i++) prog.push_back(8'($urandom));
        send_prog("full_last", 1'b1, 1);
        wait_run("full_last");
        verify("full_last", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Boot-time stage directly upstream of the single-cycle CPU. It receives the program as a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit words. It writes those words into the instruction memory write port and zero-fills the unused remainder of the memory. It holds the CPU in reset until loading is complete, then asserts the CPU start and reset-release signals.

Parameters:
DEPTH, 128, instruction memory depth in 32-bit words.
ADDR_W, 7, word-address width; DEPTH must equal 2**ADDR_W.

Ports:
clk_i  input  1  clock; all state updates on its rising edge.
rst_i  input  1  synchronous reset, active-high.
byte_i  input  8  program byte.
byte_valid_i  input  1  byte_i is valid this cycle.
byte_last_i  input  1  qualifies byte_i as the final program byte.
byte_ready_o  output  1  loader accepts a byte this cycle.
imem_we_o  output  1  instruction memory write strobe; one-cycle pulse per word.
imem_addr_o  output  ADDR_W  word address for the write.
imem_data_o  output  32  word data for the write.
cpu_rst_o  output  1  drives CPU rst_i; 0 holds the CPU in reset, 1 releases it.
start_o  output  1  drives CPU start_i.
loaded_words_o  output  ADDR_W+1  number of program words written, excluding zero-fill.
error_o  output  1  sticky: a byte was offered after loading finished.

Behaviour:
- Handshake: a byte is accepted on a clock edge where byte_valid_i and byte_ready_o are both 1.
- Reset values (rst_i=1 at an edge):
  - State is LOAD.
  - byte_ready_o=1, imem_we_o=0, imem_addr_o=0, imem_data_o=0.
  - cpu_rst_o=0, start_o=0, loaded_words_o=0, error_o=0.
  - Byte lane counter and assembly register are cleared.
- Reset applies from any state, including mid-word and mid-fill. A partial word is discarded. Memory already written is not cleared; the next load overwrites it.
- States are LOAD, FILL and RUN.
- LOAD:
  - byte_ready_o=1.
  - Byte lane counter (0..3) selects the destination: lane 0 goes to bits [31:24], lane 1 to [23:16], lane 2 to [15:8], lane 3 to [7:0].
  - When lane 3 is accepted, or byte_last_i is accepted on any lane, the word is written next cycle: imem_we_o=1 for exactly one cycle, imem_addr_o=word count, imem_data_o=the assembled word.
  - In a word closed by byte_last_i, lanes not yet received are zero.
  - Write latency is 1 cycle after the closing byte's acceptance.
  - After each program-word write, the word count and loaded_words_o increment.
  - Back-to-back bytes at one per cycle are accepted with no stalls; ready stays high across word boundaries.
- LOAD exit:
  - If the accepted byte has byte_last_i=1 and the resulting count is less than DEPTH, go to FILL.
  - If the count reaches DEPTH (whether or not byte_last_i is set), go to RUN.
  - In both cases byte_ready_o=0 from the cycle after the closing byte.
- FILL:
  - byte_ready_o=0.
  - Each cycle, issue imem_we_o=1 with imem_addr_o=count and imem_data_o=0, then increment the internal address only; loaded_words_o is unchanged.
  - After writing address DEPTH-1, go to RUN.
  - Fill writes are contiguous: one per cycle, no gaps.
- RUN:
  - cpu_rst_o=1 and start_o=1, both held until reset.
  - imem_we_o=0, byte_ready_o=0.
  - Entered the cycle after the final imem write pulse. The CPU is never released while a write is pending.
- error_o is set to 1 on any cycle in FILL or RUN with byte_valid_i=1. It stays set until rst_i. The offered byte is dropped; loaded state and memory are unaffected.
- Address wrap: the address never wraps. Bytes beyond DEPTH words are refused (ready=0) and flagged through error_o.
- loaded_words_o saturates at DEPTH. It is ADDR_W+1 bits wide so the full value DEPTH (128) is representable.

Test Plan:
1. Reset, then 8 bytes 0x8C,0x08,0x00,0x00,0x01,0x09,0x50,0x20 with last on byte 8 → writes addr0=0x8C080000 and addr1=0x01095020, each 1 cycle after its 4th byte; then 126 zero writes to addr 2..127; cpu_rst_o=start_o=1 the cycle after the addr127 write; loaded_words_o=2.
2. 6 bytes 0x11..0x16 with last on byte 6 → addr0=0x11121314, addr1=0x15160000; loaded_words_o=2; fill covers 2..127.
3. Exactly 512 bytes with no last → 128 program writes, no fill; RUN the cycle after the addr127 write; loaded_words_o=128; a 513th valid byte → byte_ready_o=0, error_o=1, no write.
4. Load 3 bytes, assert rst_i for 1 cycle, then load 4 bytes 0xAA,0xBB,0xCC,0xDD with last → addr0=0xAABBCCDD (no stale bytes); loaded_words_o=1; error_o=0.
5. During FILL, drive byte_valid_i=1 for one cycle → error_o=1 and sticky; fill sequence unchanged; RUN reached on schedule.
6. Valid gaps: bytes at cycles 0,3,4,9 with last on the 4th → single write at cycle 10, data correct; imem_we_o never high for more than one cycle per word.
